// File: rtl/ntt_pkg.sv
// Shared types and constants for the inverse-NTT stream sequencer and its helpers.
package ntt_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } seq_state_t;

   localparam int          NTT_N          = 256;
   localparam int          NTT_ADDR_WIDTH = 8;
   localparam logic [31:0] NTT_Q          = 32'd8380417;

endpackage

// File: rtl/ntt_skid_fifo2.sv
// Two-entry FIFO that absorbs the one-cycle read latency of the engine on the drain path.
module ntt_skid_fifo2 #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_din,
   input  logic         i_pop,
   output logic [W-1:0] o_dout,
   output logic         o_empty,
   output logic [1:0]   o_count
);

   logic [W-1:0] r_mem [2];
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) r_wr_ptr <= ~r_wr_ptr;
         if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
      end
   end

   // Storage carries no reset; occupancy alone says what is valid.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_din;
   end

   assign o_dout  = r_mem[r_rd_ptr];
   assign o_empty = (r_count == 2'd0);
   assign o_count = r_count;

endmodule

// File: rtl/intt_stream_sequencer.sv
// Streams one polynomial into the inverse-NTT engine, starts it, waits for done and
// drains the results back out as a valid/ready stream; one job in flight at a time.
module intt_stream_sequencer
   import ntt_pkg::*;
#(
   parameter int N              = NTT_N,
   parameter int WIDTH          = 32,
   parameter int ADDR_WIDTH     = NTT_ADDR_WIDTH,
   parameter int TIMEOUT_CYCLES = 8192
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [WIDTH-1:0]      s_data,
   input  logic                  s_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [WIDTH-1:0]      m_data,
   output logic                  m_last,
   output logic                  eng_start,
   input  logic                  eng_done,
   output logic                  eng_load_coeff,
   output logic [ADDR_WIDTH-1:0] eng_load_addr,
   output logic [WIDTH-1:0]      eng_load_data,
   output logic [ADDR_WIDTH-1:0] eng_read_addr,
   input  logic [WIDTH-1:0]      eng_read_data,
   output logic                  busy,
   output logic                  err_last,
   output logic                  err_timeout
);

   localparam int                CW       = ADDR_WIDTH + 1;
   localparam int                TO_W     = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0]     LAST_IDX = CW'(N - 1);
   localparam logic [CW-1:0]     CNT_N    = CW'(N);
   localparam logic [TO_W-1:0]   TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0]   TO_MAX   = '1;

   seq_state_t          r_state, w_state_nxt;
   logic [CW-1:0]       r_ld_cnt, r_rd_cnt;
   logic [TO_W-1:0]     r_to_cnt;
   logic                r_err_last, r_err_timeout;
   logic                r_inflight, r_inflight_last;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic                w_beat, w_issue, w_pop, w_mismatch;
   logic                w_fifo_empty;
   logic [1:0]          w_fifo_count;
   logic [2:0]          w_occ;
   logic [WIDTH:0]      w_head;

   assign w_beat     = s_valid && (r_state == LOAD);
   assign w_mismatch = s_last != (r_ld_cnt == LAST_IDX);
   assign w_pop      = !w_fifo_empty && m_ready;
   // Occupancy counts a same-cycle pop so a steady drain issues one read per cycle.
   assign w_occ      = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};

   always_ff @(posedge clk) begin
      if (rst) r_state <= LOAD;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      s_ready     = 1'b0;
      eng_start   = 1'b0;
      w_issue     = 1'b0;
      case (r_state)
         LOAD: begin
            s_ready = 1'b1;
            if (w_beat && (r_ld_cnt == LAST_IDX)) w_state_nxt = START;
         end
         START: begin
            eng_start   = 1'b1;
            w_state_nxt = WAIT;
         end
         WAIT: begin
            if (eng_done) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            w_issue = (r_rd_cnt != CNT_N) && (w_occ < 3'd2);
            if (w_pop && w_head[WIDTH]) w_state_nxt = LOAD;
         end
         default: w_state_nxt = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ld_cnt      <= '0;
         r_rd_cnt      <= '0;
         r_to_cnt      <= '0;
         r_err_last    <= 1'b0;
         r_err_timeout <= 1'b0;
         r_inflight    <= 1'b0;
         r_rd_addr     <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_beat) begin
            r_ld_cnt <= r_ld_cnt + 1'b1;
            // The first beat of a job starts a fresh error record.
            if (r_ld_cnt == '0) begin
               r_err_last    <= w_mismatch;
               r_err_timeout <= 1'b0;
            end else begin
               r_err_last <= r_err_last | w_mismatch;
            end
         end
         if (r_state == WAIT) begin
            if (eng_done) begin
               r_to_cnt <= '0;
            end else begin
               if (r_to_cnt != TO_MAX) r_to_cnt <= r_to_cnt + 1'b1;
               if (r_to_cnt == TO_LIMIT) r_err_timeout <= 1'b1;
            end
         end
         if (w_issue) begin
            r_rd_cnt  <= r_rd_cnt + 1'b1;
            r_rd_addr <= r_rd_cnt[ADDR_WIDTH-1:0];
         end
         if ((r_state == DRAIN) && w_pop && w_head[WIDTH]) begin
            r_ld_cnt <= '0;
            r_rd_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      r_inflight_last <= (r_rd_cnt == LAST_IDX);
   end

   ntt_skid_fifo2 #(.W(WIDTH + 1)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_inflight),
      .i_din   ({r_inflight_last, eng_read_data}),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   assign m_valid        = !w_fifo_empty;
   assign m_data         = m_valid ? w_head[WIDTH-1:0] : '0;
   assign m_last         = m_valid & w_head[WIDTH];
   assign eng_load_coeff = w_beat;
   assign eng_load_addr  = r_ld_cnt[ADDR_WIDTH-1:0];
   assign eng_load_data  = w_beat ? s_data : '0;
   assign eng_read_addr  = w_issue ? r_rd_cnt[ADDR_WIDTH-1:0] : r_rd_addr;
   assign busy           = !((r_state == LOAD) && (r_ld_cnt == '0));
   assign err_last       = r_err_last;
   assign err_timeout    = r_err_timeout;

endmodule
